apb_slave_regfile: RTL

APB completer that terminates the slave side of our APB bus and implements a small register bank for downstream control.
- Provides a read-only ID register, a read-only completed-transfer counter, and NUM_REGS-2 read/write registers.
- Wait states are programmable by parameter; PSLVERR is raised on bad accesses.
- Drives the bench's master-side agent and monitor; register 2 is exported as a control vector.

---
 rtl/apb_slave_regfile.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/apb_slave_regfile.sv
// APB completer with a small register bank: read-only ID at word 0,
// read-only completed-transfer counter at word 1, and read/write words
// from 2 upward. Word 2 is exported as ctrl_o. Access latency is
// WAIT_STATES+1 cycles, and bad accesses complete with PSLVERR.
module apb_slave_regfile #(
  parameter int unsigned NUM_REGS    = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [31:0] PADDR,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic [31:0] ctrl_o
);

  localparam int unsigned IDXW = $clog2(NUM_REGS);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [IDXW-1:0] idx_q;
  logic            pwrite_q;
  logic            err_q;
  logic [31:0]     xfer_cnt_q;
  logic [31:0]     rw_q [2:NUM_REGS-1];

  logic            setup;
  logic            complete;
  logic            ok_done;
  logic            wr_en;
  logic [29:0]     idx_full;
  logic            dec_err;

  // Address decode for the setup phase currently on the bus. The word index
  // is kept wide so out-of-range addresses are caught before truncation.
  assign idx_full = 30'((PADDR - BASE_ADDR) >> 2);
  assign dec_err  = (PADDR < BASE_ADDR)
                 || (PADDR[1:0] != 2'b00)
                 || (idx_full >= 30'(NUM_REGS))
                 || (PWRITE && (idx_full <= 30'd1));

  // Next-state logic: setup captures, access counts down wait states, and
  // dropping PSEL before completion aborts the transfer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    setup    = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          setup   = 1'b1;
          cnt_d   = 4'(WAIT_STATES);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          state_d = IDLE;
        end else if (!PENABLE) begin
          // A fresh setup phase restarts the transfer.
          setup = 1'b1;
          cnt_d = 4'(WAIT_STATES);
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and wait counter.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture address, direction and error verdict at each setup phase.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      idx_q    <= '0;
      pwrite_q <= 1'b0;
      err_q    <= 1'b0;
    end else if (setup) begin
      idx_q    <= idx_full[IDXW-1:0];
      pwrite_q <= PWRITE;
      err_q    <= dec_err;
    end
  end

  assign ok_done = complete && !err_q;
  assign wr_en   = ok_done && pwrite_q;

  // Completed-transfer counter: counts OKAY reads and writes, wraps freely.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      xfer_cnt_q <= 32'd0;
    end else if (ok_done) begin
      xfer_cnt_q <= xfer_cnt_q + 32'd1;
    end
  end

  // Read/write register words; PWDATA is taken at the completion edge.
  for (genvar gi = 2; gi < NUM_REGS; gi++) begin : g_rw
    always_ff @(posedge PCLK) begin
      if (PRESET) begin
        rw_q[gi] <= 32'd0;
      end else if (wr_en && (idx_q == IDXW'(gi))) begin
        rw_q[gi] <= PWDATA;
      end
    end
  end

  assign PREADY  = (state_q == ACCESS) && (cnt_q == 4'd0);
  assign PSLVERR = PREADY && err_q;
  assign ctrl_o  = rw_q[2];

  // Read data is driven only during an OKAY read completion, zero otherwise.
  always_comb begin
    PRDATA = 32'd0;
    if (PREADY && !pwrite_q && !err_q) begin
      if (idx_q == IDXW'(0)) begin
        PRDATA = ID_VALUE;
      end else if (idx_q == IDXW'(1)) begin
        PRDATA = xfer_cnt_q;
      end else begin
        PRDATA = rw_q[idx_q];
      end
    end
  end

endmodule
